// File: rtl/reg_to_obi_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | reg_to_obi_bridge: replays one register-bus access as one OBI transaction,  |
// | with a response timeout that answers the register side early.  Rev 1.0     |
// +-----------------------------------------------------------------------------+

package reg_to_obi_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module reg_to_obi_bridge
  import reg_to_obi_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_resp_i,
  output logic      busy_o,
  output logic      timeout_o
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_ADDR      = 2'd1;
  localparam logic [1:0]  S_RESP      = 2'd2;
  localparam logic [1:0]  S_DONE      = 2'd3;
  localparam logic        C_TO_EN     = (TimeoutCycles != 0);
  localparam logic [15:0] C_TO_LAST   = 16'(TimeoutCycles - 1);
  localparam logic [31:0] C_ERR_RDATA = 32'hBADC_AB1E;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [15:0] r_cnt;
  logic        r_orphan;
  logic        r_timeout;
  logic        w_accept;
  logic        w_in_flight;
  logic        w_rvalid_resp;
  logic        w_fire;

  assign w_accept      = (r_state == S_IDLE) && reg_req_i.valid;
  assign w_in_flight   = (r_state == S_ADDR) || (r_state == S_RESP);
  assign w_rvalid_resp = (r_state == S_RESP) && obi_resp_i.rvalid;
  // A completing rvalid in the expiry cycle wins over the timeout.
  assign w_fire = C_TO_EN && w_in_flight && !r_orphan &&
                  (r_cnt == C_TO_LAST) && !w_rvalid_resp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (reg_req_i.valid) w_state_nxt = S_ADDR;
      S_ADDR:  if (obi_resp_i.gnt) w_state_nxt = S_RESP;
      S_RESP:  if (obi_resp_i.rvalid) w_state_nxt = r_orphan ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    obi_req_o = '0;
    reg_rsp_o = '0;
    if (r_state == S_ADDR) begin
      obi_req_o.req   = 1'b1;
      obi_req_o.we    = r_we;
      obi_req_o.be    = r_be;
      obi_req_o.addr  = r_addr;
      obi_req_o.wdata = r_wdata;
    end
    // The timeout answer is registered so no path runs from obi_resp_i to reg_rsp_o.
    if (r_timeout) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = 1'b1;
      reg_rsp_o.rdata = C_ERR_RDATA;
    end else if (r_state == S_DONE) begin
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.rdata = r_rdata;
    end
    busy_o    = (r_state != S_IDLE);
    timeout_o = r_timeout;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we      <= 1'b0;
      r_be      <= 4'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_cnt     <= 16'h0;
      r_orphan  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_fire;
      if (w_accept) begin
        r_we    <= reg_req_i.write;
        r_addr  <= reg_req_i.addr & ~32'h3;
        r_wdata <= reg_req_i.wdata;
        r_be    <= reg_req_i.write ? reg_req_i.wstrb : 4'hF;
      end
      if (r_state == S_IDLE) begin
        r_cnt <= 16'h0;
      end else if (w_in_flight && !r_orphan) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_fire) begin
        r_orphan <= 1'b1;
      end else if (w_rvalid_resp) begin
        r_orphan <= 1'b0;
      end
      if (w_rvalid_resp && !r_orphan) begin
        r_rdata <= r_we ? 32'h0 : obi_resp_i.rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_to_obi_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_reg_to_obi_bridge: directed stimulus with a queue scoreboard and a       |
// | negedge monitor for the OBI request and register response sides. Rev 1.0   |
// +-----------------------------------------------------------------------------+

module tb_reg_to_obi_bridge;
  import reg_to_obi_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i;
  reg_req_t  reg_req_i;
  reg_rsp_t  reg_rsp_o;
  obi_req_t  obi_req_o;
  obi_resp_t obi_resp_i;
  logic      busy_o;
  logic      timeout_o;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_exp_t;

  typedef struct packed {
    logic        error;
    logic [31:0] rdata;
  } rsp_exp_t;

  obi_exp_t obi_q[$];
  rsp_exp_t rsp_q[$];
  obi_exp_t e;
  rsp_exp_t r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_len = 0;
  int last_req_len = 0;
  int t0;
  int lat;

  reg_to_obi_bridge #(.TimeoutCycles(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .reg_req_i  (reg_req_i),
    .reg_rsp_o  (reg_rsp_o),
    .obi_req_o  (obi_req_o),
    .obi_resp_i (obi_resp_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk_i) begin
    if (rst_i) begin
      req_len = 0;
    end else begin
      if (obi_req_o.req) begin
        req_len++;
        check("obi_req_expected", obi_q.size() != 0, 1);
        if (obi_q.size() != 0) begin
          e = obi_q[0];
          check("obi_addr", obi_req_o.addr, e.addr);
          check("obi_we_be", {obi_req_o.we, obi_req_o.be}, {e.we, e.be});
          check("obi_wdata", obi_req_o.wdata, e.wdata);
          if (obi_resp_i.gnt) begin
            void'(obi_q.pop_front());
            last_req_len = req_len;
            req_len = 0;
          end
        end
      end
      if (reg_rsp_o.ready) begin
        check("rsp_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          check("rsp_error", reg_rsp_o.error, r.error);
          check("rsp_rdata", reg_rsp_o.rdata, r.rdata);
          check("rsp_timeout_pulse", timeout_o, r.error);
        end
      end else if (timeout_o) begin
        check("timeout_without_ready", timeout_o, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !obi_req_o.req; i++) step();
    check("req_seen", obi_req_o.req, 1);
  endtask

  task automatic grant(input int gw);
    for (int i = 0; i < gw; i++) step();
    obi_resp_i.gnt = 1'b1;
    step();
    obi_resp_i.gnt = 1'b0;
  endtask

  task automatic respond(input int rw, input logic [31:0] data);
    for (int i = 0; i < rw; i++) step();
    obi_resp_i.rvalid = 1'b1;
    obi_resp_i.rdata  = data;
    step();
    obi_resp_i.rvalid = 1'b0;
    obi_resp_i.rdata  = 32'h0;
  endtask

  task automatic wait_ready(input int start, output int l);
    for (int i = 0; i < 50 && !reg_rsp_o.ready; i++) step();
    check("ready_seen", reg_rsp_o.ready, 1);
    l = cyc - start;
  endtask

  task automatic txn(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input int gw, input int rw,
                     input logic [31:0] slv_rdata, input logic [31:0] exp_rdata);
    int s;
    int l;
    obi_q.push_back('{wr, exp_be, exp_addr, wdata});
    rsp_q.push_back('{1'b0, exp_rdata});
    reg_req_i = '{1'b1, wr, addr, wdata, strb};
    s = cyc;
    wait_req();
    grant(gw);
    respond(rw, slv_rdata);
    wait_ready(s, l);
    check({name, "_latency"}, l, 3 + gw + rw);
    check({name, "_req_len"}, last_req_len, gw + 1);
    step();
    reg_req_i.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    reg_req_i  = '0;
    obi_resp_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    check("reset_obi_req", obi_req_o == '0, 1);
    check("reset_reg_rsp", reg_rsp_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_timeout", timeout_o, 0);
    rst_i = 1'b0;
    step();

    txn("read_min", 1'b0, 32'h2000_0006, 32'h0, 4'h0, 32'h2000_0004, 4'hF,
        0, 0, 32'h1234_5678, 32'h1234_5678);
    txn("write_gnt_stall", 1'b1, 32'h1000_0103, 32'hCAFE_F00D, 4'b0101, 32'h1000_0100, 4'b0101,
        5, 0, 32'hFFFF_FFFF, 32'h0);
    txn("read_b2b", 1'b0, 32'h2000_00FF, 32'h0, 4'h3, 32'h2000_00FC, 4'hF,
        1, 2, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
    txn("rvalid_at_expiry", 1'b0, 32'h2000_0008, 32'h0, 4'h0, 32'h2000_0008, 4'hF,
        3, 3, 32'h0F0F_1234, 32'h0F0F_1234);

    // Timeout with no grant, then a stalled request behind the drain.
    obi_q.push_back('{1'b0, 4'hF, 32'h3000_0010, 32'h0});
    rsp_q.push_back('{1'b1, 32'hBADC_AB1E});
    reg_req_i = '{1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'h0};
    t0 = cyc;
    wait_ready(t0, lat);
    check("to_latency", lat, 9);
    check("to_pulse", timeout_o, 1);
    check("to_req_held", obi_req_o.req, 1);
    step();
    check("to_pulse_one_cycle", timeout_o, 0);
    obi_q.push_back('{1'b1, 4'b1100, 32'h3000_0020, 32'h5555_AAAA});
    rsp_q.push_back('{1'b0, 32'h0});
    reg_req_i = '{1'b1, 1'b1, 32'h3000_0021, 32'h5555_AAAA, 4'b1100};
    repeat (3) begin
      step();
      check("stall_no_ready", reg_rsp_o.ready, 0);
      check("stall_req_held", obi_req_o.req, 1);
    end
    grant(0);
    check("drain_req_dropped", obi_req_o.req, 0);
    step();
    check("drain_no_ready", reg_rsp_o.ready, 0);
    respond(0, 32'hDEAD_BEEF);
    check("drain_idle", busy_o, 0);
    check("drain_no_ready2", reg_rsp_o.ready, 0);
    t0 = cyc;
    wait_req();
    grant(0);
    respond(0, 32'h0BAD_0BAD);
    wait_ready(t0, lat);
    check("post_drain_latency", lat, 3);
    step();
    reg_req_i.valid = 1'b0;
    step();

    // Reset while waiting for grant.
    reg_req_i = '{1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0};
    wait_req();
    #1 rst_i = 1'b1;
    #1;
    check("rst_req_drop", obi_req_o.req, 0);
    check("rst_busy_drop", busy_o, 0);
    obi_q.delete();
    rsp_q.delete();
    reg_req_i = '0;
    step();
    rst_i = 1'b0;
    step();
    txn("read_after_rst", 1'b0, 32'h4000_0007, 32'h0, 4'h0, 32'h4000_0004, 4'hF,
        0, 1, 32'h7777_0001, 32'h7777_0001);

    // Stray grant and rvalid while idle.
    obi_resp_i = '{1'b1, 1'b1, 32'hFFFF_0000};
    repeat (3) begin
      step();
      check("stray_busy", busy_o, 0);
      check("stray_ready", reg_rsp_o.ready, 0);
      check("stray_req", obi_req_o.req, 0);
    end
    obi_resp_i = '0;
    step();
    check("queues_drained", obi_q.size() + rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
